// File: rtl/lcd_mode_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_mode_arbiter
//
// Shares the single 8-bit LCD character path between the calculator and the
// puzzle-game producers. The raw mode_switch is synchronised and debounced.
// The current owner's characters are forwarded through a valid/ready
// handshake. Each ownership change emits one clear character, followed by a
// guard gap before the new owner is served.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   mode_switch  in   raw switch; 1 = calculator, 0 = puzzle
//   calc_valid   in   calculator has a char
//   calc_char    in   calculator char
//   calc_ready   out  calculator char accepted this cycle
//   puzz_valid   in   puzzle has a char
//   puzz_char    in   puzzle char
//   puzz_ready   out  puzzle char accepted this cycle
//   lcd_busy     in   LCD driver cannot accept a write
//   lcd_out      out  registered char to LCD (holds when lcd_we=0)
//   lcd_we       out  one-cycle write strobe qualifying lcd_out
//   lcd_col      out  column of the next write, 0..LINE_LEN-1
//   active_mode  out  current owner (1 = calculator)
// ---------------------------------------------------------------------------
module lcd_mode_arbiter #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         GAP_CYCLES      = 2,
  parameter logic [7:0] CLR_CHAR        = 8'h01,
  parameter int         LINE_LEN        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_switch,
  input  logic       calc_valid,
  input  logic [7:0] calc_char,
  output logic       calc_ready,
  input  logic       puzz_valid,
  input  logic [7:0] puzz_char,
  output logic       puzz_ready,
  input  logic       lcd_busy,
  output logic [7:0] lcd_out,
  output logic       lcd_we,
  output logic [4:0] lcd_col,
  output logic       active_mode
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_OWN,
    ST_CLEAR,
    ST_GAP
  } state_t;

  state_t            state_reg;
  logic              owner_reg;
  logic              db_mode_reg;
  logic [1:0]        sync_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [7:0]        lcd_out_reg;
  logic              lcd_we_reg;
  logic [4:0]        lcd_col_reg;

  logic              serving;
  logic              xfer;
  logic [7:0]        xfer_char;
  logic [4:0]        col_next;

  // ---------------------------------------------------------------------
  // Synchroniser and debouncer. The debounced mode flips only after the
  // synced switch has disagreed with it for DEBOUNCE_CYCLES consecutive
  // cycles; any agreement in between restarts the count.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg    <= 2'b00;
      db_mode_reg <= 1'b0;
      db_cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], mode_switch};
      if (sync_reg[1] != db_mode_reg) begin
        if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_mode_reg <= sync_reg[1];
          db_cnt_reg  <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Handshake. Only the owner is ever served, and only while the debounced
  // mode still matches the owner: a pending mode change drops both readys
  // in the same cycle, so it wins over any pending valid. The readys are
  // also forced low while reset is held.
  // ---------------------------------------------------------------------
  assign serving    = (state_reg == ST_OWN) && (db_mode_reg == owner_reg);
  assign calc_ready = reset && serving && owner_reg && !lcd_busy;
  assign puzz_ready = reset && serving && !owner_reg && !lcd_busy;

  assign xfer      = (calc_valid && calc_ready) || (puzz_valid && puzz_ready);
  assign xfer_char = owner_reg ? calc_char : puzz_char;
  assign col_next  = (lcd_col_reg == 5'(LINE_LEN - 1)) ? 5'd0 : lcd_col_reg + 5'd1;

  // ---------------------------------------------------------------------
  // Ownership FSM with registered LCD outputs. The strobe defaults low each
  // cycle, so every write is a single-cycle pulse. The OWN->CLEAR edge
  // always takes one cycle, which keeps the last owner write and the clear
  // write from landing on consecutive cycles.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_OWN;
      owner_reg   <= 1'b0;
      gap_cnt_reg <= '0;
      lcd_out_reg <= 8'h20;
      lcd_we_reg  <= 1'b0;
      lcd_col_reg <= 5'd0;
    end else begin
      lcd_we_reg <= 1'b0;
      case (state_reg)
        ST_OWN: begin
          if (db_mode_reg != owner_reg) begin
            state_reg <= ST_CLEAR;
          end else if (xfer) begin
            lcd_out_reg <= xfer_char;
            lcd_we_reg  <= 1'b1;
            lcd_col_reg <= col_next;
          end
        end
        ST_CLEAR: begin
          if (!lcd_busy) begin
            lcd_out_reg <= CLR_CHAR;
            lcd_we_reg  <= 1'b1;
            lcd_col_reg <= 5'd0;
            gap_cnt_reg <= '0;
            state_reg   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // The new owner is whatever the debounced mode is at the end of
          // the gap; if it flipped back meanwhile, OWN sees no mismatch and
          // simply resumes with the old owner.
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
            owner_reg   <= db_mode_reg;
            gap_cnt_reg <= '0;
            state_reg   <= ST_OWN;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        default: state_reg <= ST_OWN;
      endcase
    end
  end

  assign lcd_out     = lcd_out_reg;
  assign lcd_we      = lcd_we_reg;
  assign lcd_col     = lcd_col_reg;
  assign active_mode = owner_reg;

endmodule

// File: tb/tb_lcd_mode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_mode_arbiter
//
// Directed bench for lcd_mode_arbiter. Inputs are driven 1 time unit after
// the rising edge. Readys are sampled on the falling edge, and registered
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_lcd_mode_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_switch;
  logic       calc_valid;
  logic [7:0] calc_char;
  logic       calc_ready;
  logic       puzz_valid;
  logic [7:0] puzz_char;
  logic       puzz_ready;
  logic       lcd_busy;
  logic [7:0] lcd_out;
  logic       lcd_we;
  logic [4:0] lcd_col;
  logic       active_mode;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  lcd_mode_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .mode_switch (mode_switch),
    .calc_valid  (calc_valid),
    .calc_char   (calc_char),
    .calc_ready  (calc_ready),
    .puzz_valid  (puzz_valid),
    .puzz_char   (puzz_char),
    .puzz_ready  (puzz_ready),
    .lcd_busy    (lcd_busy),
    .lcd_out     (lcd_out),
    .lcd_we      (lcd_we),
    .lcd_col     (lcd_col),
    .active_mode (active_mode)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 1: reset values, and readys low while reset is held
  task automatic test_reset();
    reset = 1'b0; mode_switch = 1'b0; lcd_busy = 1'b0;
    calc_valid = 1'b0; calc_char = 8'h00; puzz_valid = 1'b0; puzz_char = 8'h00;
    @(negedge clk);
    checks++; if (puzz_ready !== 1'b0) $display("FAIL reset_puzz_ready got %b want 0", puzz_ready); else passes++;
    checks++; if (calc_ready !== 1'b0) $display("FAIL reset_calc_ready got %b want 0", calc_ready); else passes++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (lcd_out !== 8'h20) $display("FAIL reset_lcd_out got %h want 20", lcd_out); else passes++;
    checks++; if (lcd_we !== 1'b0) $display("FAIL reset_lcd_we got %b want 0", lcd_we); else passes++;
    checks++; if (lcd_col !== 5'd0) $display("FAIL reset_lcd_col got %0d want 0", lcd_col); else passes++;
    checks++; if (active_mode !== 1'b0) $display("FAIL reset_active_mode got %b want 0", active_mode); else passes++;
  endtask

  // 2: puzzle owner streams 'A','B','C'
  task automatic test_puzzle_stream();
    logic [7:0] chars [3];
    chars = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) begin
      puzz_valid = 1'b1; puzz_char = chars[i];
      @(negedge clk);
      checks++; if (puzz_ready !== 1'b1) $display("FAIL stream_puzz_ready[%0d] got %b want 1", i, puzz_ready); else passes++;
      checks++; if (calc_ready !== 1'b0) $display("FAIL stream_calc_ready[%0d] got %b want 0", i, calc_ready); else passes++;
      step();
      checks++; if (lcd_we !== 1'b1) $display("FAIL stream_we[%0d] got %b want 1", i, lcd_we); else passes++;
      checks++; if (lcd_out !== chars[i]) $display("FAIL stream_out[%0d] got %h want %h", i, lcd_out, chars[i]); else passes++;
      $display("puzzle write %0d: char=%h col=%0d", i, lcd_out, lcd_col);
    end
    puzz_valid = 1'b0;
    checks++; if (lcd_col !== 5'd3) $display("FAIL stream_col got %0d want 3", lcd_col); else passes++;
    step();
    checks++; if (lcd_we !== 1'b0) $display("FAIL stream_idle_we got %b want 0", lcd_we); else passes++;
    checks++; if (lcd_out !== 8'h43) $display("FAIL stream_hold_out got %h want 43", lcd_out); else passes++;
  endtask

  // 4: three-cycle glitch on mode_switch is filtered out
  task automatic test_glitch();
    for (int i = 0; i < 10; i++) begin
      mode_switch = (i < 3);
      puzz_valid = 1'b1; puzz_char = 8'h61 + 8'(i);
      @(negedge clk);
      checks++; if (puzz_ready !== 1'b1) $display("FAIL glitch_puzz_ready[%0d] got %b want 1", i, puzz_ready); else passes++;
      step();
      checks++; if (lcd_we !== 1'b1) $display("FAIL glitch_we[%0d] got %b want 1", i, lcd_we); else passes++;
      checks++; if (lcd_out !== 8'h61 + 8'(i)) $display("FAIL glitch_out[%0d] got %h want %h", i, lcd_out, 8'h61 + 8'(i)); else passes++;
      $display("puzzle write (glitch) %0d: char=%h col=%0d", i, lcd_out, lcd_col);
    end
    puzz_valid = 1'b0; mode_switch = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (lcd_we !== 1'b0) $display("FAIL glitch_no_clear[%0d] got %b want 0", i, lcd_we); else passes++;
    end
    checks++; if (active_mode !== 1'b0) $display("FAIL glitch_active got %b want 0", active_mode); else passes++;
    checks++; if (lcd_col !== 5'd13) $display("FAIL glitch_col got %0d want 13", lcd_col); else passes++;
  endtask

  // 3: 0->1 mode change with both producers valid throughout
  task automatic test_mode_change();
    logic       exp_pr, exp_cr, exp_we, exp_act;
    logic [7:0] exp_out;
    mode_switch = 1'b1;
    puzz_valid = 1'b1; puzz_char = 8'h50;
    calc_valid = 1'b1; calc_char = 8'h37;
    for (int c = 1; c <= 11; c++) begin
      exp_pr = (c <= 6);
      exp_cr = (c == 11);
      @(negedge clk);
      checks++; if (puzz_ready !== exp_pr) $display("FAIL change_puzz_ready[%0d] got %b want %b", c, puzz_ready, exp_pr); else passes++;
      checks++; if (calc_ready !== exp_cr) $display("FAIL change_calc_ready[%0d] got %b want %b", c, calc_ready, exp_cr); else passes++;
      step();
      exp_we  = (c <= 6) || (c == 8) || (c == 11);
      exp_out = (c <= 7) ? 8'h50 : (c <= 10) ? 8'h01 : 8'h37;
      exp_act = (c >= 10);
      checks++; if (lcd_we !== exp_we) $display("FAIL change_we[%0d] got %b want %b", c, lcd_we, exp_we); else passes++;
      checks++; if (lcd_out !== exp_out) $display("FAIL change_out[%0d] got %h want %h", c, lcd_out, exp_out); else passes++;
      checks++; if (active_mode !== exp_act) $display("FAIL change_active[%0d] got %b want %b", c, active_mode, exp_act); else passes++;
      if (c == 8) begin
        checks++; if (lcd_col !== 5'd0) $display("FAIL change_clear_col got %0d want 0", lcd_col); else passes++;
      end
      if (c == 11) begin
        checks++; if (lcd_col !== 5'd1) $display("FAIL change_calc_col got %0d want 1", lcd_col); else passes++;
      end
      if (lcd_we === 1'b1) $display("cycle %0d write: char=%h col=%0d", c, lcd_out, lcd_col);
    end
    calc_valid = 1'b0; puzz_valid = 1'b0;
  endtask

  // 5: busy during CLEAR, then 17 calc chars wrap the column
  task automatic test_backpressure_wrap();
    int k;
    int exp_col;
    mode_switch = 1'b0; lcd_busy = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      checks++; if (calc_ready !== 1'b0 || puzz_ready !== 1'b0) $display("FAIL bp_readys[%0d] got %b%b want 00", c, calc_ready, puzz_ready); else passes++;
      step();
      checks++; if (lcd_we !== (c == 12)) $display("FAIL bp_we[%0d] got %b want %b", c, lcd_we, (c == 12)); else passes++;
      if (c == 12) begin
        checks++; if (lcd_out !== 8'h01) $display("FAIL bp_clear_out got %h want 01", lcd_out); else passes++;
        checks++; if (lcd_col !== 5'd0) $display("FAIL bp_clear_col got %0d want 0", lcd_col); else passes++;
        $display("clear write after backpressure: char=%h col=%0d", lcd_out, lcd_col);
      end
      if (c == 11) lcd_busy = 1'b0;
    end
    checks++; if (active_mode !== 1'b0) $display("FAIL bp_active got %b want 0", active_mode); else passes++;
    // back to calculator
    mode_switch = 1'b1;
    k = 0;
    while (k < 30 && active_mode !== 1'b1) begin
      step();
      k++;
    end
    checks++; if (active_mode !== 1'b1) $display("FAIL bp_return_timeout got %b want 1", active_mode); else passes++;
    for (int i = 0; i < 17; i++) begin
      calc_valid = 1'b1; calc_char = 8'h60 + 8'(i);
      @(negedge clk);
      checks++; if (calc_ready !== 1'b1 || puzz_ready !== 1'b0) $display("FAIL wrap_readys[%0d] got %b%b want 10", i, calc_ready, puzz_ready); else passes++;
      step();
      exp_col = (i < 15) ? i + 1 : i - 15;
      checks++; if (lcd_we !== 1'b1) $display("FAIL wrap_we[%0d] got %b want 1", i, lcd_we); else passes++;
      checks++; if (lcd_out !== 8'h60 + 8'(i)) $display("FAIL wrap_out[%0d] got %h want %h", i, lcd_out, 8'h60 + 8'(i)); else passes++;
      checks++; if (lcd_col !== 5'(exp_col)) $display("FAIL wrap_col[%0d] got %0d want %0d", i, lcd_col, exp_col); else passes++;
      $display("calc write %0d: char=%h col=%0d", i, lcd_out, lcd_col);
    end
    calc_valid = 1'b0;
  endtask

  // 6: asynchronous reset while in the guard gap
  task automatic test_reset_mid_gap();
    int k;
    mode_switch = 1'b0;
    k = 0;
    while (k < 30 && !(lcd_we === 1'b1 && lcd_out === 8'h01)) begin
      step();
      k++;
    end
    checks++; if (lcd_we !== 1'b1 || lcd_out !== 8'h01) $display("FAIL gap_clear_timeout got we=%b out=%h want we=1 out=01", lcd_we, lcd_out); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (lcd_out !== 8'h20) $display("FAIL gap_rst_out got %h want 20", lcd_out); else passes++;
    checks++; if (lcd_we !== 1'b0) $display("FAIL gap_rst_we got %b want 0", lcd_we); else passes++;
    checks++; if (lcd_col !== 5'd0) $display("FAIL gap_rst_col got %0d want 0", lcd_col); else passes++;
    checks++; if (active_mode !== 1'b0) $display("FAIL gap_rst_active got %b want 0", active_mode); else passes++;
    checks++; if (calc_ready !== 1'b0 || puzz_ready !== 1'b0) $display("FAIL gap_rst_readys got %b%b want 00", calc_ready, puzz_ready); else passes++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (puzz_ready !== 1'b1) $display("FAIL gap_post_puzz_ready got %b want 1", puzz_ready); else passes++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (lcd_we !== 1'b0) $display("FAIL gap_post_we[%0d] got %b want 0", i, lcd_we); else passes++;
      checks++; if (active_mode !== 1'b0) $display("FAIL gap_post_active[%0d] got %b want 0", i, active_mode); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_puzzle_stream();
    test_glitch();
    test_mode_change();
    test_backpressure_wrap();
    test_reset_mid_gap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
